// File: rtl/rtc_pkg.sv
// rtc_pkg: button/location encodings, BCD types and the digit stepping helper
package rtc_pkg;
    localparam logic [3:0] BTN_UP    = 4'b0001;
    localparam logic [3:0] BTN_LEFT  = 4'b0010;
    localparam logic [3:0] BTN_RIGHT = 4'b0100;
    localparam logic [3:0] BTN_DOWN  = 4'b1000;
    localparam logic [5:0] LOC_SEC_U = 6'b000001;
    localparam logic [5:0] LOC_SEC_T = 6'b000010;
    localparam logic [5:0] LOC_MIN_U = 6'b000100;
    localparam logic [5:0] LOC_MIN_T = 6'b001000;
    localparam logic [5:0] LOC_HR_U  = 6'b010000;
    localparam logic [5:0] LOC_HR_T  = 6'b100000;
    typedef logic [3:0] bcd_t;
    typedef struct packed {
        bcd_t hr_t;
        bcd_t hr_u;
        bcd_t min_t;
        bcd_t min_u;
        bcd_t sec_t;
        bcd_t sec_u;
    } time_t;
    function automatic bcd_t bcd_step(input bcd_t d, input bcd_t lim, input logic inc);
        return inc ? (d >= lim ? 4'd0 : d + 4'd1) : (d == 4'd0 ? lim : d - 4'd1);
    endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: periodic button sampler, one-hot press detect and LEFT/RIGHT auto-repeat
module btn_conditioner
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int HOLD_SAMPLES   = 50,
    parameter int REPEAT_SAMPLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [3:0] evt
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_SAMPLES - 1);
    localparam logic [HW-1:0] H_FULL = HW'(HOLD_SAMPLES);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_SAMPLES - 1);
    logic [DW-1:0] dcnt;
    logic [HW-1:0] age;
    logic [RW-1:0] rep;
    logic [3:0] deb, deb_q;
    logic fresh, press, held, fire;
    // fresh marks the one cycle after a sample, where deb/deb_q hold the new and previous samples
    assign press = fresh && $onehot(deb) && (deb & ~deb_q) != 4'd0;
    assign held  = fresh && deb == deb_q && (deb == BTN_LEFT || deb == BTN_RIGHT);
    assign fire  = held && (age == H_FULL ? rep == R_LAST : age == H_LAST);
    assign evt   = (press || fire) ? deb : 4'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt  <= '0;
            deb   <= '0;
            deb_q <= '0;
            fresh <= 1'b0;
            age   <= '0;
            rep   <= '0;
        end else begin
            fresh <= dcnt == D_LAST;
            dcnt  <= dcnt == D_LAST ? '0 : dcnt + 1'b1;
            if (dcnt == D_LAST) begin
                deb   <= btn;
                deb_q <= deb;
            end
            if (fresh) begin
                age <= held ? (age == H_FULL ? age : age + 1'b1) : '0;
                rep <= (held && age == H_FULL) ? (rep == R_LAST ? '0 : rep + 1'b1) : '0;
            end
        end
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD time-of-day keeper with button-driven digit adjust, blink and 12-hour view
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int HOLD_SAMPLES   = 50,
    parameter int REPEAT_SAMPLES = 10,
    parameter int BLINK_CYC      = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic        mode_12h,
    output logic [23:0] bcd,
    output logic        pm,
    output logic        sec_pulse,
    output logic        adjust_mode,
    output logic [5:0]  location,
    output logic [5:0]  blank
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);
    logic [3:0] evt;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic [4:0] cy, hr24, hr12;
    logic up, left, right, down, tc, edit, phase;
    bcd_t hr_u_lim;
    time_t tm, tm_nxt;

    btn_conditioner #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .HOLD_SAMPLES  (HOLD_SAMPLES),
        .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_btn (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .evt(evt)
    );

    assign up       = evt == BTN_UP;
    assign left     = evt == BTN_LEFT;
    assign right    = evt == BTN_RIGHT;
    assign down     = evt == BTN_DOWN;
    assign tc       = !adjust_mode && presc == P_LAST;
    assign edit     = adjust_mode && (up || left || right);
    assign hr_u_lim = tm.hr_t == 4'd2 ? 4'd3 : 4'd9;
    assign cy[0]    = tm.sec_u == 4'd9;
    assign cy[1]    = cy[0] && tm.sec_t == 4'd5;
    assign cy[2]    = cy[1] && tm.min_u == 4'd9;
    assign cy[3]    = cy[2] && tm.min_t == 4'd5;
    assign cy[4]    = cy[3] && tm.hr_u == hr_u_lim;
    assign hr24     = 5'(tm_nxt.hr_t) * 5'd10 + 5'(tm_nxt.hr_u);
    assign hr12     = hr24 == 5'd0 ? 5'd12 : hr24 > 5'd12 ? hr24 - 5'd12 : hr24;
    assign blank    = (adjust_mode && phase) ? location : 6'd0;

    always_comb begin
        tm_nxt = tm;
        if (tc) begin
            tm_nxt.sec_u = bcd_step(tm.sec_u, 4'd9, 1'b1);
            if (cy[0]) tm_nxt.sec_t = bcd_step(tm.sec_t, 4'd5, 1'b1);
            if (cy[1]) tm_nxt.min_u = bcd_step(tm.min_u, 4'd9, 1'b1);
            if (cy[2]) tm_nxt.min_t = bcd_step(tm.min_t, 4'd5, 1'b1);
            if (cy[3]) tm_nxt.hr_u  = bcd_step(tm.hr_u, hr_u_lim, 1'b1);
            if (cy[4]) tm_nxt.hr_t  = bcd_step(tm.hr_t, 4'd2, 1'b1);
        end else if (adjust_mode && (left || right)) begin
            case (location)
                LOC_SEC_U: tm_nxt.sec_u = bcd_step(tm.sec_u, 4'd9, right);
                LOC_SEC_T: tm_nxt.sec_t = bcd_step(tm.sec_t, 4'd5, right);
                LOC_MIN_U: tm_nxt.min_u = bcd_step(tm.min_u, 4'd9, right);
                LOC_MIN_T: tm_nxt.min_t = bcd_step(tm.min_t, 4'd5, right);
                LOC_HR_U:  tm_nxt.hr_u  = bcd_step(tm.hr_u, hr_u_lim, right);
                LOC_HR_T: begin
                    tm_nxt.hr_t = bcd_step(tm.hr_t, 4'd2, right);
                    if (tm_nxt.hr_t == 4'd2 && tm.hr_u > 4'd3) tm_nxt.hr_u = 4'd3;
                end
                default: ;
            endcase
        end
    end

    // bcd/pm are built from tm_nxt so the display and sec_pulse land on the same edge as the time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            tm          <= '0;
            bcd         <= '0;
            pm          <= 1'b0;
            sec_pulse   <= 1'b0;
            adjust_mode <= 1'b0;
            location    <= LOC_SEC_U;
            blink_cnt   <= '0;
            phase       <= 1'b0;
        end else begin
            presc       <= (adjust_mode || down || tc) ? '0 : presc + 1'b1;
            tm          <= tm_nxt;
            bcd         <= mode_12h ? {hr12 >= 5'd10 ? 4'd1 : 4'd0, 4'(hr12 >= 5'd10 ? hr12 - 5'd10 : hr12), tm_nxt[15:0]} : tm_nxt;
            pm          <= mode_12h && hr24 >= 5'd12;
            sec_pulse   <= tc;
            adjust_mode <= adjust_mode ^ down;
            if (adjust_mode && up) location <= {location[4:0], location[5]};
            blink_cnt   <= (!adjust_mode || edit || blink_cnt == B_LAST) ? '0 : blink_cnt + 1'b1;
            phase       <= adjust_mode && !edit && (blink_cnt == B_LAST ? !phase : phase);
        end
    end
endmodule
